rr_grant_arbiter: RTL and testbench
===================================

// Module: rr_grant_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream resource among 8 requesters.
//  Picks one winner with a rotating-priority encoder and holds the grant
//  until the owner finishes, drops its request or exceeds a hold limit.
//  Publishes the winner one-hot and as a 3-bit index.
//  Sits between the requesting agents and the shared resource's select input.
// PARAMETERS
//  N         8   number of requesters (power of two)
//  IDW       3   index width, log2(N)
//  MAX_HOLD  16  max consecutive cycles one grant may be held (>=2)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  en         in   1    arbiter enable; 0 = no new grants, force release
//  req        in   N    request vector, bit i = requester i
//  done       in   1    owner finished; releases grant this cycle
//  gnt        out  N    one-hot grant, registered
//  gnt_id     out  IDW  index of granted requester, registered
//  gnt_valid  out  1    1 while a grant is held
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hold_cnt=0,
//   state=IDLE. Reset mid-grant drops the grant immediately, no handshake.
//  States: IDLE, GRANT.
//  Pick: first set bit of req searching upward from ptr, wrapping N-1 -> 0.
//  IDLE: if en && |req -> GRANT; gnt/gnt_id/gnt_valid set next edge
//   (1-cycle latency req -> gnt); hold_cnt=0. Else stay; outputs 0.
//  GRANT: release when any of: done=1; req[gnt_id]=0; hold_cnt==MAX_HOLD-1;
//   en=0. Otherwise hold_cnt++ (saturates never reached, release first).
//  Release (done/req-drop/timeout): ptr <= gnt_id+1 mod N (wraps 7 -> 0).
//   If en && any req with the released bit masked, grant new winner at the
//   same edge (back-to-back, no idle cycle); else -> IDLE, outputs 0.
//  Release by en=0: -> IDLE, outputs 0 next edge, ptr unchanged.
//  Simultaneous done and timeout: single release, counted once.
//  A requester dropping and re-raising req in the release cycle is ignored
//   that cycle (its bit masked) and competes normally next cycle.
//  req changes on non-owner bits never affect a held grant.
//  Invariants: gnt is one-hot or zero; gnt_valid == |gnt;
//   gnt == (1 << gnt_id) whenever gnt_valid; gnt_id=0 when !gnt_valid.
//  Fairness: any continuously asserted req is granted within
//   (N-1)*MAX_HOLD + N cycles.
// STRUCTURE
//  Package arb_pkg: N, IDW, MAX_HOLD defaults; state enum {IDLE, GRANT};
//   hold counter width constant $clog2(MAX_HOLD).
//  Sub-module rr_pick (combinational): inputs req[N], ptr[IDW], mask[N];
//   outputs any, win_id[IDW]; rotate-right by ptr, 8:3 priority encode
//   (lowest index wins), add ptr back mod N.
//  Top: state reg, ptr reg, hold_cnt, output regs, release logic.
// TESTING
//  T1 reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_id=0, gnt_valid=0.
//  T2 single: en=1, req=8'b0000_0100 -> next edge gnt=8'h04, gnt_id=2;
//   done pulse -> gnt=0 next edge, ptr=3.
//  T3 rotation: req=8'hFF held, done every 2nd cycle -> gnt_id sequence
//   0,1,2,...,7,0 with no idle cycles between grants.
//  T4 timeout: req=8'b1000_0001 held, no done, MAX_HOLD=16 -> id 0 for 16
//   cycles, then id 7 for 16, then id 0 (wrap 7->0).
//  T5 enable: mid-grant on id 3, en=0 -> gnt=0 next edge, ptr stays 3;
//   en=1 with req=8'b0111_0000 -> gnt_id=4 (search from ptr 3).
//  T6 async reset mid-grant: rst_n low between edges -> outputs 0
//   immediately; after release, req=8'h80 -> gnt_id=7 (ptr back at 0).
//  Bench checks invariants every cycle and fairness bound under random req.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin grant arbiter
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDW      = 3;
  localparam int ARB_MAX_HOLD = 16;
  localparam int ARB_HCW      = $clog2(ARB_MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority picker: first unmasked request at or above ptr, wrapping
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = ARB_IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   mask,
  output logic           any,
  output logic [IDW-1:0] win_id
);

  logic [N-1:0]   w_req;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_idx;

  assign w_req = req & ~mask;
  // Bit k of the rotated vector is requester (ptr + k) mod N.
  assign w_dbl = {w_req, w_req} >> ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = IDW'(i);
    end
  end

  assign any    = |w_req;
  // IDW-bit addition wraps modulo N because N is a power of two.
  assign win_id = w_idx + ptr;

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter holding one grant until done, request drop,
// hold timeout or disable, with back-to-back hand-over to the next winner
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = ARB_IDW,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int             HCW       = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  arb_state_e     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gnt_id;
  logic [HCW-1:0] r_hold_cnt;
  logic [N-1:0]   r_gnt;
  logic           r_gnt_valid;

  logic [IDW-1:0] w_pick_ptr;
  logic [IDW-1:0] w_win_id;
  logic           w_any;
  logic           w_release;

  // While granting, the picker already searches from the post-release pointer
  // with the owner masked, so a hand-over needs no idle cycle.
  assign w_pick_ptr = (r_state == GRANT) ? r_gnt_id + IDW'(1) : r_ptr;
  assign w_release  = done || !req[r_gnt_id] || (r_hold_cnt == HOLD_LAST);

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (w_pick_ptr),
    .mask   (r_gnt),
    .any    (w_any),
    .win_id (w_win_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && w_any) begin
            r_state     <= GRANT;
            r_gnt       <= N'(1) << w_win_id;
            r_gnt_id    <= w_win_id;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (!en) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
          end else if (w_release) begin
            r_ptr      <= w_pick_ptr;
            r_hold_cnt <= '0;
            if (w_any) begin
              r_gnt    <= N'(1) << w_win_id;
              r_gnt_id <= w_win_id;
            end else begin
              r_state     <= IDLE;
              r_gnt       <= '0;
              r_gnt_id    <= '0;
              r_gnt_valid <= 1'b0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HCW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  localparam int N     = ARB_N;
  localparam int MH    = ARB_MAX_HOLD;
  localparam int BOUND = (N - 1) * MH + N;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         done  = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic         gnt_valid;

  int n_checks = 0;
  int n_errors = 0;

  bit  m_valid;
  int  m_id;
  int  m_ptr;
  int  m_hold;
  logic [11:0] sb_q[$];

  int wait_cnt[N];
  int max_wait;
  bit fair_on;

  rr_grant_arbiter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx] && !m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_step();
    int w;
    if (!m_valid) begin
      if (en && (|req)) begin
        m_valid = 1'b1;
        m_id    = pick(req, m_ptr, '0);
        m_hold  = 0;
      end
    end else if (!en) begin
      m_valid = 1'b0;
      m_id    = 0;
    end else if (done || !req[m_id] || m_hold == MH - 1) begin
      m_ptr = (m_id + 1) % N;
      w     = pick(req, m_ptr, N'(1) << m_id);
      if (w >= 0) begin
        m_id   = w;
        m_hold = 0;
      end else begin
        m_valid = 1'b0;
        m_id    = 0;
      end
    end else begin
      m_hold++;
    end
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
    m_hold  = 0;
    sb_q.delete();
  endfunction

  task automatic step();
    logic [11:0]  e;
    logic [N-1:0] exp_gnt;
    model_step();
    exp_gnt = m_valid ? (N'(1) << m_id) : '0;
    sb_q.push_back({m_valid, 3'(m_id), exp_gnt});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(0), 32'(1));
    end else begin
      e = sb_q.pop_front();
      check_eq("gnt", 32'(gnt), 32'(e[7:0]));
      check_eq("gnt_id", 32'(gnt_id), 32'(e[10:8]));
      check_eq("gnt_valid", 32'(gnt_valid), 32'(e[11]));
    end
    check_eq("inv_onehot", 32'($onehot0(gnt)), 32'(1));
    check_eq("inv_valid", 32'(gnt_valid), 32'(|gnt));
    if (gnt_valid) check_eq("inv_map", 32'(gnt), 32'(N'(1) << gnt_id));
    else           check_eq("inv_id0", 32'(gnt_id), 32'(0));
    if (fair_on) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i])      wait_cnt[i] = 0;
        else if (req[i]) wait_cnt[i]++;
        else             wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'(0));
    check_eq("rst_gnt_id", 32'(gnt_id), 32'(0));
    check_eq("rst_gnt_valid", 32'(gnt_valid), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    fair_on  = 1'b0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    // T1: reset with every requester asserted
    en  = 1'b1;
    req = 8'hFF;
    apply_reset();

    // T2: single requester, release on done, then ptr=3 picks 3 over 0
    apply_reset();
    req = 8'b0000_0100;
    step();
    check_eq("t2_gnt", 32'(gnt), 32'(8'h04));
    check_eq("t2_id", 32'(gnt_id), 32'(2));
    done = 1'b1;
    step();
    check_eq("t2_release", 32'(gnt), 32'(0));
    done = 1'b0;
    req  = 8'b0000_1001;
    step();
    check_eq("t2_ptr3", 32'(gnt_id), 32'(3));

    // T3: rotation with done every second cycle, no idle gaps
    req = 8'h00;
    apply_reset();
    req = 8'hFF;
    step();
    check_eq("t3_first", 32'(gnt_id), 32'(0));
    for (int k = 1; k <= 8; k++) begin
      done = 1'b0;
      step();
      check_eq("t3_hold", 32'(gnt_id), 32'((k - 1) % N));
      done = 1'b1;
      step();
      check_eq("t3_next", 32'(gnt_id), 32'(k % N));
      check_eq("t3_noidle", 32'(gnt_valid), 32'(1));
    end
    done = 1'b0;

    // T4: hold timeout with wrap 7 -> 0
    apply_reset();
    req = 8'b1000_0001;
    step();
    check_eq("t4_first", 32'(gnt_id), 32'(0));
    for (int k = 1; k < MH; k++) begin
      step();
      check_eq("t4_id0", 32'(gnt_id), 32'(0));
    end
    for (int k = 0; k < MH; k++) begin
      step();
      check_eq("t4_id7", 32'(gnt_id), 32'(7));
    end
    step();
    check_eq("t4_wrap", 32'(gnt_id), 32'(0));

    // T5: disable mid-grant keeps ptr at 3
    apply_reset();
    req = 8'b0000_0100;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'b0000_1000;
    step();
    check_eq("t5_id3", 32'(gnt_id), 32'(3));
    step();
    en = 1'b0;
    step();
    check_eq("t5_off", 32'(gnt), 32'(0));
    en  = 1'b1;
    req = 8'b0111_0000;
    step();
    check_eq("t5_id4", 32'(gnt_id), 32'(4));

    // T6: asynchronous reset between edges
    apply_reset();
    req = 8'b0000_1000;
    step();
    step();
    check_eq("t6_held", 32'(gnt_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_async_gnt", 32'(gnt), 32'(0));
    check_eq("t6_async_id", 32'(gnt_id), 32'(0));
    check_eq("t6_async_valid", 32'(gnt_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h80;
    step();
    check_eq("t6_id7", 32'(gnt_id), 32'(7));

    // Random traffic with en held high: fairness bound
    apply_reset();
    req     = 8'($urandom);
    fair_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      done = ($urandom_range(0, 3) == 0);
      step();
    end
    fair_on = 1'b0;
    check_eq("fair_bound", 32'(max_wait <= BOUND), 32'(1));

    // Random traffic including enable toggles
    for (int c = 0; c < 1500; c++) begin
      req  = 8'($urandom);
      done = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
